// File: rtl/mcp_receiver.sv
// Receiving half of a toggle-handshake multi-cycle-path CDC: synchronizes b_req, captures b_data
// into a 2-entry FIFO and returns an a_ack toggle per captured word.
module mcp_receiver #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
   input  logic             reset,
   input  logic             clk_a,
   input  logic             b_req,
   input  logic [WIDTH-1:0] b_data,
   output logic             a_ack,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] a_data,
   output logic [1:0]       a_count
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   last_seen_q;
   logic                   ack_q;
   logic [WIDTH-1:0]       mem_q [2];
   logic                   wr_ptr_q;
   logic                   rd_ptr_q;
   logic [1:0]             count_q;
   logic [1:0]             count_d;
   logic                   pending;
   logic                   full;
   logic                   pop;
   logic                   capture;

   always_ff @(posedge clk_a or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], b_req};
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   // b_data is only trusted once the synchronized toggle differs from the last word taken.
   always_comb begin
      pending = (req_s != last_seen_q);
      full    = (count_q == 2'd2);
      pop     = a_valid & a_ready;
      capture = pending & (~full | pop);
      count_d = count_q;
      if (capture && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !capture) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk_a or posedge reset) begin
      if (reset) begin
         last_seen_q <= 1'b0;
         ack_q       <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
      end else begin
         count_q <= count_d;
         if (capture) begin
            last_seen_q <= req_s;
            ack_q       <= ~ack_q;
            wr_ptr_q    <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   // Storage is written only on a capture edge so b_data is never sampled while it may be moving.
   always_ff @(posedge clk_a or posedge reset) begin
      if (reset) begin
         mem_q[0] <= RESET_VAL;
         mem_q[1] <= RESET_VAL;
      end else if (capture) begin
         mem_q[wr_ptr_q] <= b_data;
      end
   end

   assign a_ack   = ack_q;
   assign a_valid = (count_q != 2'd0);
   assign a_data  = mem_q[rd_ptr_q];
   assign a_count = count_q;

endmodule

// File: tb/tb_mcp_receiver.sv
// Bench for mcp_receiver: directed handshake cases on a 2-stage instance, then randomized
// toggle-protocol traffic on a 3-stage instance, both checked through per-instance scoreboards.
module tb_mcp_receiver;

   localparam int NWORDS = 1000;

   logic       clk_a = 1'b0;
   logic       reset;

   logic       r2, ack2, v2, rdy2;
   logic [7:0] d2, q2;
   logic [1:0] cnt2;

   logic       r3, ack3, v3, rdy3;
   logic [7:0] d3, q3;
   logic [1:0] cnt3;

   int total = 0;
   int bad   = 0;
   int got3  = 0;
   int acks3 = 0;

   logic [7:0] exp2[$];
   logic [7:0] exp3[$];

   always #5 clk_a = ~clk_a;

   mcp_receiver #(
      .WIDTH      (8),
      .SYNC_STAGES(2),
      .RESET_VAL  (8'hC3)
   ) dut2 (
      .reset  (reset),
      .clk_a  (clk_a),
      .b_req  (r2),
      .b_data (d2),
      .a_ack  (ack2),
      .a_valid(v2),
      .a_ready(rdy2),
      .a_data (q2),
      .a_count(cnt2)
   );

   mcp_receiver #(
      .WIDTH      (8),
      .SYNC_STAGES(3)
   ) dut3 (
      .reset  (reset),
      .clk_a  (clk_a),
      .b_req  (r3),
      .b_data (d3),
      .a_ack  (ack3),
      .a_valid(v3),
      .a_ready(rdy3),
      .a_data (q3),
      .a_count(cnt3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_a);
      #1;
   endtask

   task automatic send2(input logic [7:0] w);
      d2 = w;
      r2 = ~r2;
      exp2.push_back(w);
   endtask

   task automatic wait_ack2(input logic prev, input string name);
      int n = 0;
      while (ack2 === prev && n < 20) begin
         cyc();
         n++;
      end
      check(name, ack2, !prev);
   endtask

   // Scoreboard monitor for the directed instance.
   always @(negedge clk_a) begin
      if (!reset && v2 && rdy2) begin
         if (exp2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dut2 unexpected word: got %h want none", q2);
         end else begin
            check("dut2 order", q2, exp2.pop_front());
         end
      end
   end

   // Scoreboard monitor for the stress instance, also watching head stability under stall.
   logic [7:0] prev_q3;
   logic       prev_hold3 = 1'b0;
   always @(negedge clk_a) begin
      if (reset) begin
         prev_hold3 = 1'b0;
      end else begin
         if (prev_hold3 && v3) check("dut3 head stable", q3, prev_q3);
         if (v3 && rdy3) begin
            if (exp3.size() == 0) begin
               total++;
               bad++;
               $display("FAIL dut3 unexpected word: got %h want none", q3);
            end else begin
               check("dut3 order", q3, exp3.pop_front());
            end
            got3++;
         end
         prev_hold3 = v3 && !rdy3;
         prev_q3    = q3;
      end
   end

   initial begin
      logic a;
      reset = 1'b1;
      r2 = 1'b0; d2 = 8'h00; rdy2 = 1'b0;
      r3 = 1'b0; d3 = 8'h00; rdy3 = 1'b0;
      repeat (3) cyc();
      check("reset valid", v2, 0);
      check("reset count", cnt2, 0);
      check("reset ack", ack2, 0);
      check("reset data", q2, 8'hC3);
      reset = 1'b0;
      cyc();

      // Single word and exact latency
      send2(8'hA5);
      cyc();
      cyc();
      check("030 not early valid", v2, 0);
      check("030 not early ack", ack2, 0);
      cyc();
      check("030 valid", v2, 1);
      check("030 data", q2, 8'hA5);
      check("030 ack", ack2, 1);
      check("030 count", cnt2, 1);
      rdy2 = 1'b1;
      cyc();
      rdy2 = 1'b0;
      check("030 valid after pop", v2, 0);
      check("030 count after pop", cnt2, 0);

      // Back-pressure with a third word pending on a full buffer
      a = ack2; send2(8'h11); wait_ack2(a, "031 ack 11");
      a = ack2; send2(8'h22); wait_ack2(a, "031 ack 22");
      a = ack2; send2(8'h33);
      repeat (8) cyc();
      check("031 count full", cnt2, 2);
      check("031 ack held", ack2, a);
      check("031 head", q2, 8'h11);
      rdy2 = 1'b1;
      cyc();
      rdy2 = 1'b0;
      check("031 count on pop", cnt2, 2);
      check("031 ack on pop", ack2, !a);
      check("031 head after pop", q2, 8'h22);
      rdy2 = 1'b1;
      cyc();
      cyc();
      rdy2 = 1'b0;
      check("031 drained", cnt2, 0);

      // Capture and pop on the same edge
      a = ack2; send2(8'h40); wait_ack2(a, "032 ack 40");
      check("032 count one", cnt2, 1);
      a = ack2; send2(8'h41);
      cyc();
      cyc();
      rdy2 = 1'b1;
      cyc();
      rdy2 = 1'b0;
      check("032 count", cnt2, 1);
      check("032 data", q2, 8'h41);
      check("032 ack", ack2, !a);
      rdy2 = 1'b1;
      cyc();
      rdy2 = 1'b0;
      check("032 drained", cnt2, 0);

      // No spurious capture with b_req idle
      a = ack2;
      repeat (20) cyc();
      check("033 count", cnt2, 0);
      check("033 ack", ack2, a);
      check("033 valid", v2, 0);

      // Reset with a full buffer and a pending word
      a = ack2; send2(8'h50); wait_ack2(a, "034 ack 50");
      a = ack2; send2(8'h51); wait_ack2(a, "034 ack 51");
      a = ack2; send2(8'h52);
      repeat (6) cyc();
      check("034 count full", cnt2, 2);
      check("034 ack held", ack2, a);
      #2 reset = 1'b1;
      #1;
      check("034 reset valid", v2, 0);
      check("034 reset count", cnt2, 0);
      check("034 reset ack", ack2, 0);
      check("034 reset data", q2, 8'hC3);
      r2 = 1'b0;
      exp2.delete();
      repeat (3) cyc();
      reset = 1'b0;
      repeat (12) cyc();
      check("034 no capture count", cnt2, 0);
      check("034 no capture ack", ack2, 0);
      check("034 no capture valid", v2, 0);

      // Randomized toggle-protocol traffic
      fork
         begin : sender
            logic prev;
            int   n;
            for (int i = 0; i < NWORDS; i++) begin
               repeat ($urandom_range(0, 3)) cyc();
               prev = ack3;
               d3   = 8'($urandom);
               exp3.push_back(d3);
               r3   = ~r3;
               n    = 0;
               while (ack3 === prev && n < 200) begin
                  cyc();
                  n++;
               end
               if (ack3 === prev) begin
                  check("035 ack timeout", ack3, !prev);
                  break;
               end
               acks3++;
            end
         end
         begin : consumer
            int n = 0;
            while (got3 < NWORDS && n < 40000) begin
               rdy3 = 1'($urandom_range(0, 1));
               cyc();
               n++;
            end
            rdy3 = 1'b0;
         end
      join
      repeat (4) cyc();
      check("035 delivered", got3, NWORDS);
      check("035 acks", acks3, NWORDS);
      check("035 leftover", exp3.size(), 0);
      check("035 final count", cnt3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mcp_receiver.md
MCP_RECEIVER -- requirements
Module: mcp_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on the request toggle; legal values 2 to 4.
REQ-003 SHALL have parameter RESET_VAL, default all-zero WIDTH bits: reset value of a_data.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port clk_a, input, 1 bit: clock clk_a, the receiving domain clock.
REQ-006 SHALL have port b_req, input, 1 bit: request toggle from the foreign domain; each transition is one word offered.
REQ-007 SHALL have port b_data, input, WIDTH bits: word from the foreign domain, held stable from the b_req transition until the matching a_ack transition.
REQ-008 SHALL have port a_ack, output, 1 bit: acknowledge toggle back to the foreign domain; the foreign domain synchronizes it.
REQ-009 SHALL have port a_valid, output, 1 bit: buffer head holds a word.
REQ-010 SHALL have port a_ready, input, 1 bit: consumer accepts the head this cycle.
REQ-011 SHALL have port a_data, output, WIDTH bits: buffer head word.
REQ-012 SHALL have port a_count, output, 2 bits: buffer occupancy, 0 to 2.

Function
REQ-013 SHALL pass b_req through a SYNC_STAGES-flop chain clocked by clk_a; req_s is the last stage.
REQ-014 SHALL keep a register last_seen and treat req_s != last_seen as a pending word.
REQ-015 SHALL capture a pending word on a clk_a edge when a_count < 2, or when a_count == 2 and a pop occurs in the same cycle.
REQ-016 On capture, at the same edge, SHALL write b_data into the buffer, set last_seen to req_s, and toggle a_ack.
REQ-017 SHALL NOT sample b_data for the buffer at any edge other than a capture edge.
REQ-018 SHALL be a 2-entry FIFO: a_valid = (a_count != 0); a_data = oldest entry; words delivered in arrival order.
REQ-019 Pop = a_valid & a_ready; pop with a_valid low SHALL have no effect.
REQ-020 On simultaneous capture and pop, a_count SHALL stay unchanged, the old head SHALL retire, and the new word SHALL enqueue.
REQ-021 Full buffer with a pending word and no pop: SHALL hold the word pending with no capture and no a_ack toggle; capture SHALL occur at the first edge where REQ-015 holds.
REQ-022 Latency: with the buffer not full, a b_req transition sampled at clk_a edge 1 SHALL assert a_valid (or advance the tail) and toggle a_ack after edge SYNC_STAGES+1.
REQ-023 At most one word SHALL be captured per b_req transition; no word SHALL be captured while req_s == last_seen.
REQ-024 a_data SHALL remain stable while a_valid is high and no pop occurs.
REQ-025 All outputs SHALL be registered or driven from registers; there SHALL be no combinational path from b_req or b_data to any output.
REQ-026 Buffer pointers SHALL wrap modulo 2.

Reset
REQ-027 On reset the following SHALL be cleared asynchronously: all synchronizer stages and last_seen = 0; a_ack = 0; a_count = 0; a_valid = 0; a_data = RESET_VAL; pointers = 0.
REQ-028 Reset mid-transfer SHALL discard buffered and pending words; the foreign side SHALL reset its toggle to 0 under the same reset.
REQ-029 After reset deassertion, the first capture SHALL require b_req = 1.

Verification
REQ-030 Single word: WIDTH=8, SYNC_STAGES=2; b_data=0xA5, b_req 0->1 -> after 3 edges a_valid=1, a_data=0xA5, a_ack=1, a_count=1; a_ready=1 for one cycle -> a_valid=0.
REQ-031 Back-pressure: a_ready=0; send 0x11, 0x22, 0x33, each after the previous a_ack toggle -> a_count=2, a_ack toggles only twice, 0x33 stays pending; one pop -> 0x33 captured at that edge, a_ack toggles, a_count stays 2; output order 0x11, 0x22, 0x33.
REQ-032 Simultaneous push and pop: a_count=1 holding 0x40; capture of 0x41 on the same edge as a pop -> a_count=1, a_data=0x41.
REQ-033 No spurious capture: b_req held constant for 20 cycles after a completed transfer -> a_count and a_ack unchanged.
REQ-034 Reset mid-operation: a_count=2 plus one pending word; assert reset -> a_valid=0, a_count=0, a_ack=0, a_data=RESET_VAL; after release with b_req=0 -> no capture.
REQ-035 Stress: random a_ready and a randomly delayed toggle-protocol sender with SYNC_STAGES=3 over 1000 words -> no loss, no duplication, in-order delivery, b_data never changes while a transfer is unacknowledged.
